// File: rtl/pixel_stream_serializer.sv
// Purpose: serializes whole NUM_CH-channel pixels into one channel per output beat with SOF/EOL/EOF framing.
// Latency: pixel accepted at edge N drives channel 0 from cycle N+1; NUM_CH beats per pixel, no bubbles when fed.
// Backpressure: out_ready low holds the current beat; in_ready only while empty or on the accepted final channel.
// Optional build macro SER_CHECKSUM_EN: appends a per-frame modulo-2^DATA_W checksum beat (out_ch == NUM_CH).
module pixel_stream_serializer #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    localparam int CH_W  = $clog2(NUM_CH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     out_eof,
    output logic                     busy
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // ST_INIT keeps in_ready low for the first cycle after reset release.
    typedef enum logic [1:0] {
        ST_INIT,
        ST_EMPTY,
        ST_SHIFT
`ifdef SER_CHECKSUM_EN
        , ST_CKSUM
`endif
    } state_t;

    state_t                    state, state_nxt;
    logic [NUM_CH*DATA_W-1:0]  pix;
    logic [CH_W-1:0]           ch;
    logic [COL_W-1:0]          col, col_nxt;
    logic [ROW_W-1:0]          row, row_nxt;
    logic [DATA_W-1:0]         ch_dat;
    logic                      last_ch, last_col, last_row, frame_last;
    logic                      in_xfer, out_xfer, pix_done;
`ifdef SER_CHECKSUM_EN
    logic [DATA_W-1:0]         acc;
`endif

    assign last_ch    = (ch == CH_LAST);
    assign last_col   = (col == COL_LAST);
    assign last_row   = (row == ROW_LAST);
    assign frame_last = last_col && last_row;
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    assign pix_done   = (state == ST_SHIFT) && out_ready && last_ch;

    // Select the channel currently being shifted out of the holding register.
    always_comb begin
        ch_dat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == CH_W'(k)) begin
                ch_dat = pix[k*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and beat/flag outputs; flags only ever asserted alongside out_valid.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_ch    = '0;
        out_sof   = 1'b0;
        out_eol   = 1'b0;
        out_eof   = 1'b0;
        case (state)
            ST_INIT: begin
                state_nxt = ST_EMPTY;
            end
            ST_EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                out_valid = 1'b1;
                out_data  = ch_dat;
                out_ch    = ch;
                out_sof   = (ch == '0) && (col == '0) && (row == '0);
                out_eol   = last_ch && last_col;
`ifdef SER_CHECKSUM_EN
                // The frame's final data beat is followed by the checksum, so no accept-through there.
                in_ready  = last_ch && out_ready && !frame_last;
`else
                out_eof   = last_ch && frame_last;
                in_ready  = last_ch && out_ready;
`endif
                if (pix_done) begin
                    if (in_valid && in_ready) begin
                        state_nxt = ST_SHIFT;
                    end
`ifdef SER_CHECKSUM_EN
                    else if (frame_last) begin
                        state_nxt = ST_CKSUM;
                    end
`endif
                    else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
`ifdef SER_CHECKSUM_EN
            ST_CKSUM: begin
                out_valid = 1'b1;
                out_data  = acc;
                out_ch    = CH_W'(NUM_CH);
                out_eof   = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_EMPTY;
                end
            end
`endif
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Position of the pixel following this cycle; advances when the last channel leaves.
    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (pix_done) begin
            if (last_col) begin
                col_nxt = '0;
                row_nxt = last_row ? '0 : row + 1'b1;
            end else begin
                col_nxt = col + 1'b1;
            end
        end
    end

    // Holding register, channel counter and frame position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix <= '0;
            ch  <= '0;
            col <= '0;
            row <= '0;
        end else begin
            if (in_xfer) begin
                pix <= in_pixel;
            end
            if (in_xfer || pix_done) begin
                ch <= '0;
            end else if ((state == ST_SHIFT) && out_ready) begin
                ch <= ch + 1'b1;
            end
            col <= col_nxt;
            row <= row_nxt;
        end
    end

    // Frame-in-progress flag; a new frame's first pixel wins over the old frame's closing beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else if (in_xfer && (col_nxt == '0) && (row_nxt == '0)) begin
            busy <= 1'b1;
        end else if (out_xfer && out_eof) begin
            busy <= 1'b0;
        end
    end

`ifdef SER_CHECKSUM_EN
    // Running sum of every data beat in the frame, cleared once the checksum beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if ((state == ST_CKSUM) && out_ready) begin
            acc <= '0;
        end else if ((state == ST_SHIFT) && out_ready) begin
            acc <= acc + ch_dat;
        end
    end
`endif

endmodule

// File: doc/pixel_stream_serializer.md
Name: pixel_stream_serializer

Overview:
Synthesizable, parametrised successor to the bench-side byte serializer. Accepts whole pixels (NUM_CH channels of DATA_W bits) on a valid/ready input and emits one channel per accepted output beat, in channel order 0..NUM_CH-1 (R, G, B for the default). Tracks column and row positions and flags start-of-frame, end-of-line and end-of-frame. Sits between the frame source (memory reader or camera front end) and the serial link/processing pipeline.

Parameters:
DATA_W, 8, bits per channel sample
NUM_CH, 3, channels per pixel (>=1)
IMG_W, 640, pixels per line (>=1)
IMG_H, 480, lines per frame (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_pixel holds a valid pixel
in_ready  out  1  block can take a pixel this cycle
in_pixel  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts beat
out_data  out  DATA_W  current channel sample
out_ch  out  max(1,$clog2(NUM_CH+1))  channel index of current beat
out_sof  out  1  beat is channel 0 of pixel (0,0)
out_eol  out  1  beat is last channel of last pixel in a line
out_eof  out  1  final beat of the frame
busy  out  1  frame in progress (first pixel accepted, final beat not yet accepted)

Behaviour:
- Reset (rst_n low, async): all outputs 0; in_ready 0 while asserted, goes 1 on first clk after release; ch/col/row counters 0; holding register cleared.
- Handshakes: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. out_data/out_ch/flags stable while out_valid && !out_ready.
- FSM: EMPTY -> on input transfer latch pixel, ch=0 -> SHIFT. SHIFT: out_valid=1, out_data = channel ch of register. On output transfer: if ch<NUM_CH-1, ch++; else pixel done.
- Pixel done: in_ready=1 in SHIFT when ch==NUM_CH-1 && out_ready (accept-through): simultaneous input transfer reloads register, ch=0, stays SHIFT with no bubble. Otherwise -> EMPTY.
- in_ready = (state==EMPTY) || (state==SHIFT && ch==NUM_CH-1 && out_ready); never in CKSUM.
- Latency: pixel accepted at edge N -> channel 0 on out_data after edge N (valid from cycle N+1). Full throughput: NUM_CH output beats per pixel, zero idle cycles when source always valid and sink always ready.
- Position: col increments on pixel done; col==IMG_W-1 -> col=0, row++; row==IMG_H-1 at that point -> row=0 (frame wrap), next pixel starts new frame with out_sof.
- Flags are combinational from state/counters, qualified by out_valid. NUM_CH==1: out_ch always 0, every beat is a pixel boundary. IMG_W==1: out_eol on every pixel's last channel.
- busy: set on input transfer when col==0&&row==0; cleared on output transfer of out_eof beat (same cycle set takes priority if next frame's pixel accepted through).
- Reset mid-frame: all state discarded; next accepted pixel is (0,0).

Optional Feature:
SER_CHECKSUM_EN. Defined: after the last channel of the last pixel of a frame, FSM enters CKSUM and emits one extra beat: out_data = modulo-2^DATA_W sum of all data beats of that frame, out_ch = NUM_CH, out_eol=0; out_eof moves to this beat; in_ready=0 during CKSUM; accumulator clears on its transfer and on reset. Undefined: no CKSUM state, no accumulator, out_eof on last data beat, out_ch never equals NUM_CH.

Test Plan:
- Reset: rst_n low mid-stream with out_valid=1 -> out_valid, out_eof, busy, in_ready all 0 immediately (async); after release first pixel gets out_sof.
- Single pixel, defaults, in_pixel=0x332211, out_ready=1 -> beats 0x11/ch0, 0x22/ch1, 0x33/ch2 on 3 consecutive cycles, out_sof on first.
- IMG_W=4, IMG_H=2, source/sink always ready, pixels 0..7 -> 24 beats no gaps; out_eol on beats 12 and 24; out_eof on beat 24 only; beat 25 carries out_sof.
- Backpressure: out_ready low 5 cycles during ch1 -> out_data/out_ch/flags held, in_ready 0, no data lost or duplicated.
- Accept-through: in_valid high, out_ready high on final channel -> in_ready 1 that cycle, next pixel's ch0 appears next cycle.
- SER_CHECKSUM_EN, IMG_W=2, IMG_H=1, NUM_CH=3, pixels 0x030201, 0x060504 -> 7th beat out_data=0x15, out_ch=3, out_eof=1; sixth beat out_eof=0.
